// File: rtl/dmem_responder_pkg.sv
// dmem_pkg: shared FSM/op types and width helpers for dmem_responder.
// No ports; imported by rr_arbiter and dmem_responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} dmem_state_t;
  typedef enum logic {OP_READ, OP_WRITE} dmem_op_t;
  localparam int CNT_BITS = 16;
  function automatic int idx_bits(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: LSU data-memory request/response channels for NUM_PORTS ports.
// master: LSU side (drives valid/address/write data, receives ready/read data).
// slave: responder side.
interface dmem_responder_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic [NUM_PORTS-1:0] mem_read_valid;
  logic [NUM_PORTS*ADDR_BITS-1:0] mem_read_address;
  logic [NUM_PORTS-1:0] mem_read_ready;
  logic [NUM_PORTS*DATA_BITS-1:0] mem_read_data;
  logic [NUM_PORTS-1:0] mem_write_valid;
  logic [NUM_PORTS*ADDR_BITS-1:0] mem_write_address;
  logic [NUM_PORTS*DATA_BITS-1:0] mem_write_data;
  logic [NUM_PORTS-1:0] mem_write_ready;
  modport master (
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input mem_read_ready, mem_read_data, mem_write_ready
  );
  modport slave (
    input mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/dmem_responder_arb.sv
// rr_arbiter: combinational round-robin pick among unmasked requesters.
// Ports: req/mask (NUM_PORTS) and ptr (search start) in; one-hot gnt and gnt_idx out.
module rr_arbiter import dmem_pkg::*; #(
  parameter int NUM_PORTS = 4,
  localparam int IW = idx_bits(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] mask,
  input  logic [IW-1:0]        ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IW-1:0]        gnt_idx
);
  logic [NUM_PORTS-1:0] cand;
  logic [IW-1:0] idx;
  assign cand = req & ~mask;
  // Walk offsets from farthest to nearest so the candidate closest to ptr wins last.
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_PORTS);
      if (cand[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        gnt_idx = idx;
      end
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data memory serving NUM_PORTS LSU read/write channels, one request at a time.
// Ports: clk, reset (sync, active-low), bus (dmem_responder_if.slave), busy,
// rd_count/wr_count (completed ops; live only with DMEM_PERF_CNT_EN defined, else 0).
module dmem_responder import dmem_pkg::*; #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8,
  parameter int LATENCY = 2,
  localparam int IW = idx_bits(NUM_PORTS),
  localparam int LW = idx_bits(LATENCY)
) (
  input  logic                clk,
  input  logic                reset,
  dmem_responder_if.slave     bus,
  output logic                busy,
  output logic [CNT_BITS-1:0] rd_count,
  output logic [CNT_BITS-1:0] wr_count
);
  dmem_state_t state, state_n;
  dmem_op_t op;
  logic [IW-1:0] rr_ptr, port, gnt_idx;
  logic [NUM_PORTS-1:0] req, mask, gnt, port_oh;
  logic [ADDR_BITS-1:0] addr;
  logic [DATA_BITS-1:0] wdata;
  logic [LW-1:0] lat_cnt;
  logic commit;
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];
  logic [ADDR_BITS-1:0] raddr [NUM_PORTS];
  logic [ADDR_BITS-1:0] waddr [NUM_PORTS];
  logic [DATA_BITS-1:0] wdat [NUM_PORTS];
  logic [DATA_BITS-1:0] rd_data [NUM_PORTS];
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign raddr[g] = bus.mem_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign waddr[g] = bus.mem_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wdat[g] = bus.mem_write_data[g*DATA_BITS +: DATA_BITS];
    assign bus.mem_read_data[g*DATA_BITS +: DATA_BITS] = rd_data[g];
  end
  assign req = bus.mem_read_valid | bus.mem_write_valid;
  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .req(req),
    .mask(mask),
    .ptr(rr_ptr),
    .gnt(gnt),
    .gnt_idx(gnt_idx)
  );
  always_comb begin
    port_oh = '0;
    port_oh[port] = 1'b1;
    state_n = state == IDLE ? (|gnt ? ACCESS : IDLE) :
              state == ACCESS ? (lat_cnt == '0 ? RESPOND : ACCESS) : IDLE;
    commit = state == ACCESS && lat_cnt == '0;
    busy = state != IDLE;
    bus.mem_read_ready = state == RESPOND && op == OP_READ ? port_oh : '0;
    bus.mem_write_ready = state == RESPOND && op == OP_WRITE ? port_oh : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      mask <= '0;
      port <= '0;
      op <= OP_READ;
      addr <= '0;
      wdata <= '0;
      lat_cnt <= '0;
      for (int i = 0; i < NUM_PORTS; i++) rd_data[i] <= '0;
    end else begin
      state <= state_n;
      // The LSU's registered valid lingers one cycle after ready; hide that port for one IDLE cycle.
      mask <= state == RESPOND ? port_oh : '0;
      if (state == IDLE && |gnt) begin
        port <= gnt_idx;
        op <= bus.mem_read_valid[gnt_idx] ? OP_READ : OP_WRITE;
        addr <= bus.mem_read_valid[gnt_idx] ? raddr[gnt_idx] : waddr[gnt_idx];
        wdata <= wdat[gnt_idx];
        lat_cnt <= LW'(LATENCY - 1);
        rr_ptr <= gnt_idx == IW'(NUM_PORTS - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (state == ACCESS) lat_cnt <= lat_cnt - 1'b1;
      if (commit && op == OP_READ) rd_data[port] <= mem[addr];
    end
  end
  // Array keeps its contents across reset; a reset edge still blocks an in-flight write.
  always_ff @(posedge clk)
    if (reset && commit && op == OP_WRITE) mem[addr] <= wdata;
`ifdef DMEM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == RESPOND) begin
      if (op == OP_READ && rd_count != '1) rd_count <= rd_count + 1'b1;
      if (op == OP_WRITE && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder (4 ports, 8-bit addr/data, LATENCY 2).
module tb_dmem_responder;
  localparam int NP = 4;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
  logic [15:0] rd_count, wr_count;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  dmem_responder_if #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB)) bus();
  dmem_responder #(.NUM_PORTS(NP), .ADDR_BITS(AB), .DATA_BITS(DB), .LATENCY(LAT)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .rd_count(rd_count),
    .wr_count(wr_count)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] rdata(input logic [1:0] p);
    return bus.mem_read_data[p*DB +: DB];
  endfunction
  task automatic wait_rdy(input logic [1:0] p, input bit rd, output int n);
    n = 0;
    do begin
      tick();
      n++;
      check("onehot", 32'($countones({bus.mem_read_ready, bus.mem_write_ready}) <= 1), 1);
    end while (!(rd ? bus.mem_read_ready[p] : bus.mem_write_ready[p]) && n < 20);
  endtask
  task automatic serve(input logic [1:0] p, input bit rd, input logic [7:0] a, input logic [7:0] d);
    int n;
    logic [3:0] oh;
    oh = 4'b0001 << p;
    if (rd) begin
      bus.mem_read_valid[p] = 1'b1;
      bus.mem_read_address[p*AB +: AB] = a;
    end else begin
      bus.mem_write_valid[p] = 1'b1;
      bus.mem_write_address[p*AB +: AB] = a;
      bus.mem_write_data[p*DB +: DB] = d;
    end
    wait_rdy(p, rd, n);
    check("latency", 32'(n), 3);
    check("ready_vec", 32'({bus.mem_read_ready, bus.mem_write_ready}), rd ? 32'({oh, 4'b0}) : 32'({4'b0, oh}));
    if (rd) check("read_data", 32'(rdata(p)), 32'(d));
    bus.mem_read_valid[p] = 1'b0;
    bus.mem_write_valid[p] = 1'b0;
    tick();
    check("pulse_end", 32'({bus.mem_read_ready, bus.mem_write_ready}), 0);
    tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.mem_read_valid = '0;
    bus.mem_write_valid = '0;
    bus.mem_read_address = '0;
    bus.mem_write_address = '0;
    bus.mem_write_data = '0;
    tick();
    tick();
    check("rst_ready", 32'({bus.mem_read_ready, bus.mem_write_ready}), 0);
    check("rst_rdata", 32'(bus.mem_read_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_counts", 32'({rd_count, wr_count}), 0);
    reset = 1'b1;
    // Port 2 write 0xA5 -> 0x10, LSU-style valid held one cycle past ready
    bus.mem_write_valid[2] = 1'b1;
    bus.mem_write_address[2*AB +: AB] = 8'h10;
    bus.mem_write_data[2*DB +: DB] = 8'hA5;
    tick();
    check("busy_access", 32'(busy), 1);
    tick();
    check("wr2_early", 32'(bus.mem_write_ready), 0);
    tick();
    check("wr2_ready", 32'(bus.mem_write_ready), 4'b0100);
    check("wr2_no_rd", 32'(bus.mem_read_ready), 0);
    tick();
    tick();
    check("mask_no_regrant", 32'(busy), 0);
    bus.mem_write_valid[2] = 1'b0;
    tick();
    check("idle_after", 32'(busy), 0);
    serve(2, 1'b1, 8'h10, 8'hA5);
    // Seed 0x30..0x33, then all four ports read at once
    for (int p = 0; p < 4; p++) serve(2'(p), 1'b0, 8'(8'h30 + p), 8'(8'hC0 + p));
    for (int p = 0; p < 4; p++) begin
      bus.mem_read_valid[p] = 1'b1;
      bus.mem_read_address[p*AB +: AB] = 8'(8'h30 + p);
    end
    for (int k = 0; k < 4; k++) begin
      wait_rdy(2'(k), 1'b1, n);
      check("rr_spacing", 32'(n), k == 0 ? 3 : 4);
      check("rr_order", 32'(bus.mem_read_ready), 32'(4'b0001 << k));
      check("rr_data", 32'(rdata(2'(k))), 32'(8'hC0 + k));
      bus.mem_read_valid[k] = 1'b0;
    end
    tick();
    tick();
    check("rr_no_double", 32'({busy, bus.mem_read_ready}), 0);
    check("rr_hold0", 32'(rdata(0)), 'hC0);
    // Port 1 read+write together: read first, write after mask cycle
    serve(0, 1'b0, 8'h20, 8'h99);
    bus.mem_read_valid[1] = 1'b1;
    bus.mem_write_valid[1] = 1'b1;
    bus.mem_read_address[1*AB +: AB] = 8'h20;
    bus.mem_write_address[1*AB +: AB] = 8'h20;
    bus.mem_write_data[1*DB +: DB] = 8'h3C;
    wait_rdy(1, 1'b1, n);
    check("both_rd_lat", 32'(n), 3);
    check("both_rd_first", 32'(bus.mem_write_ready), 0);
    check("both_rd_data", 32'(rdata(1)), 'h99);
    bus.mem_read_valid[1] = 1'b0;
    wait_rdy(1, 1'b0, n);
    check("both_wr_lat", 32'(n), 5);
    bus.mem_write_valid[1] = 1'b0;
    tick();
    tick();
    serve(1, 1'b1, 8'h20, 8'h3C);
    // Reset on the commit-pending ACCESS cycle of a write 0x77 -> 0x05
    serve(0, 1'b0, 8'h05, 8'h11);
    bus.mem_write_valid[0] = 1'b1;
    bus.mem_write_address[0*AB +: AB] = 8'h05;
    bus.mem_write_data[0*DB +: DB] = 8'h77;
    tick();
    tick();
    check("abort_busy", 32'(busy), 1);
    reset = 1'b0;
    bus.mem_write_valid[0] = 1'b0;
    tick();
    check("abort_busy_clr", 32'(busy), 0);
    check("abort_ready", 32'({bus.mem_read_ready, bus.mem_write_ready}), 0);
    check("abort_rdata", 32'(bus.mem_read_data), 0);
    check("abort_counts", 32'({rd_count, wr_count}), 0);
    reset = 1'b1;
    tick();
    tick();
    check("abort_no_ready", 32'({busy, bus.mem_read_ready, bus.mem_write_ready}), 0);
    serve(0, 1'b1, 8'h05, 8'h11);
    // Counters: 3 reads, 2 writes since reset
    serve(3, 1'b0, 8'h40, 8'h55);
    serve(3, 1'b0, 8'h41, 8'h66);
    serve(3, 1'b1, 8'h40, 8'h55);
    serve(2, 1'b1, 8'h41, 8'h66);
`ifdef DMEM_PERF_CNT_EN
    check("rd_count", 32'(rd_count), 3);
    check("wr_count", 32'(wr_count), 2);
`else
    check("rd_count", 32'(rd_count), 0);
    check("wr_count", 32'(wr_count), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
